// File: rtl/cnn_pkg.sv
// Shared types and helpers for the cnn feature-map read-out path.
package cnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } ofm_state_e;

  // Index width for a dimension of size n; a size-1 dimension still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_idx_counter.sv
// Nested (m, r, c) wrap counter: c is innermost, m outermost.
module cnn_idx_counter
  import cnn_pkg::*;
#(
  parameter int M_p = 4,
  parameter int R_p = 4,
  parameter int C_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic                    clr_i,
  output logic [idx_w(M_p)-1:0]   m_o,
  output logic [idx_w(R_p)-1:0]   r_o,
  output logic [idx_w(C_p)-1:0]   c_o,
  output logic [idx_w(M_p)-1:0]   m_nxt_o,
  output logic [idx_w(R_p)-1:0]   r_nxt_o,
  output logic [idx_w(C_p)-1:0]   c_nxt_o,
  output logic                    wrap_o
);

  localparam int MW = idx_w(M_p);
  localparam int RW = idx_w(R_p);
  localparam int CW = idx_w(C_p);

  localparam logic [MW-1:0] M_MAX = MW'(M_p - 1);
  localparam logic [RW-1:0] R_MAX = RW'(R_p - 1);
  localparam logic [CW-1:0] C_MAX = CW'(C_p - 1);

  logic [MW-1:0] m_q, m_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    m_d = m_q;
    r_d = r_q;
    c_d = c_q;
    if (clr_i) begin
      m_d = '0;
      r_d = '0;
      c_d = '0;
    end else if (en_i) begin
      if (c_q == C_MAX) begin
        c_d = '0;
        if (r_q == R_MAX) begin
          r_d = '0;
          m_d = (m_q == M_MAX) ? '0 : m_q + 1'b1;
        end else begin
          r_d = r_q + 1'b1;
        end
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      m_q <= '0;
      r_q <= '0;
      c_q <= '0;
    end else begin
      m_q <= m_d;
      r_q <= r_d;
      c_q <= c_d;
    end
  end

  assign m_o     = m_q;
  assign r_o     = r_q;
  assign c_o     = c_q;
  assign m_nxt_o = m_d;
  assign r_nxt_o = r_d;
  assign c_nxt_o = c_d;
  assign wrap_o  = (m_q == M_MAX) && (r_q == R_MAX) && (c_q == C_MAX);

endmodule

// File: rtl/cnn_ofm_streamer.sv
// Streams a finished output feature map as m/r/c-ordered valid/ready beats.
module cnn_ofm_streamer
  import cnn_pkg::*;
#(
  parameter int M_p = 4,
  parameter int R_p = 4,
  parameter int C_p = 4,
  parameter int W_p = 32
) (
  input  logic                                        clk_i,
  input  logic                                        reset_n_i,
  input  logic                                        start_i,
  input  logic [M_p-1:0][R_p-1:0][C_p-1:0][W_p-1:0]   fm_i,
  output logic [W_p-1:0]                              data_o,
  output logic [idx_w(M_p)-1:0]                       m_o,
  output logic [idx_w(R_p)-1:0]                       r_o,
  output logic [idx_w(C_p)-1:0]                       c_o,
  output logic                                        valid_o,
  input  logic                                        ready_i,
  output logic                                        last_o,
  output logic                                        busy_o,
  output logic                                        done_o
);

  localparam int MW = idx_w(M_p);
  localparam int RW = idx_w(R_p);
  localparam int CW = idx_w(C_p);

  ofm_state_e     state_q, state_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W_p-1:0] data_q, data_d;

  logic [MW-1:0]  m_nxt;
  logic [RW-1:0]  r_nxt;
  logic [CW-1:0]  c_nxt;
  logic           wrap;
  logic           xfer;
  logic           cnt_clr;
  logic           cnt_en;
  logic [W_p-1:0] elem_sel;

  assign xfer    = valid_q & ready_i;
  assign cnt_clr = (state_q == ST_IDLE) & start_i;
  assign cnt_en  = (state_q == ST_STREAM) & xfer & ~wrap;

  cnn_idx_counter #(
    .M_p (M_p),
    .R_p (R_p),
    .C_p (C_p)
  ) u_idx (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (cnt_en),
    .clr_i     (cnt_clr),
    .m_o       (m_o),
    .r_o       (r_o),
    .c_o       (c_o),
    .m_nxt_o   (m_nxt),
    .r_nxt_o   (r_nxt),
    .c_nxt_o   (c_nxt),
    .wrap_o    (wrap)
  );

  // Select by the counter's next value so data_o lands on the same edge as the indices.
  assign elem_sel = fm_i[m_nxt][r_nxt][c_nxt];

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_STREAM;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          data_d  = elem_sel;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          if (wrap) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            data_d  = elem_sel;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign last_o  = valid_q & wrap;

endmodule

// File: tb/tb_cnn_ofm_streamer.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_cnn_ofm_streamer;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  m;
    logic [1:0]  r;
    logic [1:0]  c;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic [3:0][3:0][3:0][31:0] fm = '0;
  logic [31:0] data;
  logic [1:0]  m_idx, r_idx, c_idx;
  logic        valid, last, busy, done;

  logic        start1 = 1'b0;
  logic        ready1 = 1'b1;
  logic [0:0][0:0][0:0][31:0] fm1 = '0;
  logic [31:0] data1;
  logic        m1, r1, c1;
  logic        valid1, last1, busy1, done1;

  int vectors = 0;
  int miscompares = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  cnn_ofm_streamer #(.M_p(4), .R_p(4), .C_p(4), .W_p(32)) u_dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .fm_i(fm),
    .data_o(data), .m_o(m_idx), .r_o(r_idx), .c_o(c_idx),
    .valid_o(valid), .ready_i(ready), .last_o(last), .busy_o(busy), .done_o(done)
  );

  cnn_ofm_streamer #(.M_p(1), .R_p(1), .C_p(1), .W_p(32)) u_dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start1), .fm_i(fm1),
    .data_o(data1), .m_o(m1), .r_o(r1), .c_o(c1),
    .valid_o(valid1), .ready_i(ready1), .last_o(last1), .busy_o(busy1), .done_o(done1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a beat visible at negedge with ready high transfers on the next rising edge.
  logic        stall_prev = 1'b0;
  logic [39:0] snap;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {24'd0, valid, data, m_idx, r_idx, c_idx, last}, {24'd0, snap});
      if (valid && ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got data %h with no beat expected", data);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("beat", {25'd0, data, m_idx, r_idx, c_idx, last}, {25'd0, e});
        end
        beat_cnt++;
      end
      if (done) begin
        done_cnt++;
        check("done_idle", {62'd0, busy, valid}, 64'd0);
        check("done_sb_empty", 64'(sb.size()), 64'd0);
      end
      stall_prev = valid && !ready;
      snap = {valid, data, m_idx, r_idx, c_idx, last};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_fm();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++)
          fm[i][j][k] = $urandom();
  endtask

  // Reference model: the whole map in m, r, c order; only the final element is last.
  task automatic start_stream();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++) begin
          beat_t e;
          e.data = fm[i][j][k];
          e.m = 2'(i);
          e.r = 2'(j);
          e.c = 2'(k);
          e.last = (i * 16 + j * 4 + k) == 63;
          sb.push_back(e);
        end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_state", {24'd0, valid, busy, m_idx, r_idx, c_idx, data},
          {24'd0, 1'b1, 1'b1, 6'd0, fm[0][0][0]});
  endtask

  task automatic run_to_done(input bit rand_ready, output int cycles);
    cycles = 0;
    forever begin
      ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      cycles++;
      if (done) break;
      if (cycles > 400) begin
        vectors++;
        miscompares++;
        $display("FAIL done_timeout: got no done after %0d cycles, required within 400", cycles);
        break;
      end
    end
  endtask

  initial begin
    int cyc, b0, d0;

    // Asynchronous reset with no clock edge in between.
    #2 reset_n = 1'b0;
    #1 check("reset_async", {26'd0, data, m_idx, r_idx, c_idx, valid, last, busy, done}, 64'd0);
    #20 reset_n = 1'b1;
    repeat (3) tick();
    check("idle_after_reset", {26'd0, data, m_idx, r_idx, c_idx, valid, last, busy, done}, 64'd0);

    // Full stream with the index pattern and ready held high: no bubbles.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++)
          fm[i][j][k] = 32'(16 * i + 4 * j + k);
    b0 = beat_cnt; d0 = done_cnt;
    ready = 1'b1;
    start_stream();
    run_to_done(1'b0, cyc);
    check("no_bubble_cycles", 64'(cyc), 64'd64);
    tick();
    check("back_to_idle", {61'd0, done, busy, valid}, 64'd0);
    check("full_beats", 64'(beat_cnt - b0), 64'd64);
    check("full_dones", 64'(done_cnt - d0), 64'd1);

    // Backpressure on beat 5 for three cycles.
    b0 = beat_cnt;
    ready = 1'b1;
    start_stream();
    repeat (5) tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold", {21'd0, valid, data, m_idx, r_idx, c_idx, last},
            {21'd0, 1'b1, 32'd5, 2'd0, 2'd1, 2'd1, 1'b0});
    end
    run_to_done(1'b0, cyc);
    check("bp_tail_cycles", 64'(cyc), 64'd59);
    tick();
    check("bp_beats", 64'(beat_cnt - b0), 64'd64);

    // Start while streaming and during the done cycle is ignored.
    randomize_fm();
    b0 = beat_cnt; d0 = done_cnt;
    ready = 1'b1;
    start_stream();
    repeat (20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(1'b0, cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ignore_start_done", {61'd0, busy, valid, done}, 64'd0);
    repeat (3) tick();
    check("still_idle", {62'd0, busy, valid}, 64'd0);
    check("busy_start_beats", 64'(beat_cnt - b0), 64'd64);
    check("busy_start_dones", 64'(done_cnt - d0), 64'd1);

    // Reset mid-stream, then restart from the origin.
    randomize_fm();
    ready = 1'b1;
    start_stream();
    repeat (11) tick();
    #2 reset_n = 1'b0;
    #1 check("midreset_outputs", {26'd0, data, m_idx, r_idx, c_idx, valid, last, busy, done}, 64'd0);
    sb.delete();
    #3 reset_n = 1'b1;
    tick();
    randomize_fm();
    b0 = beat_cnt;
    start_stream();
    run_to_done(1'b1, cyc);
    tick();
    check("restart_beats", 64'(beat_cnt - b0), 64'd64);

    // Random maps with random backpressure.
    for (int s = 0; s < 3; s++) begin
      randomize_fm();
      b0 = beat_cnt; d0 = done_cnt;
      start_stream();
      run_to_done(1'b1, cyc);
      tick();
      check("rand_beats", 64'(beat_cnt - b0), 64'd64);
      check("rand_dones", 64'(done_cnt - d0), 64'd1);
    end
    ready = 1'b0;

    // Degenerate 1x1x1 map.
    fm1[0][0][0] = 32'hDEADBEEF;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("deg_beat", {28'd0, valid1, last1, busy1, m1, r1, c1, data1},
          {28'd0, 1'b1, 1'b1, 1'b1, 3'd0, 32'hDEADBEEF});
    tick();
    check("deg_done", {60'd0, done1, valid1, busy1, last1}, {60'd0, 4'b1000});
    tick();
    check("deg_done_pulse", {63'd0, done1}, 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
